// File: rtl/approx_mul_pkg.sv
// Shared definitions for the pipelined approximate multiplier: width derivation,
// approximate-cell truth tables and the stage-valid bundle.
package approx_mul_pkg;

   function automatic int unsigned calc_w(input int unsigned wa, input int unsigned wb);
      return wa + wb;
   endfunction

   function automatic logic approx_s(input logic x, input logic y);
      return ~(x & y);
   endfunction

   function automatic logic approx_c(input logic y, input logic z);
      return ~y & z;
   endfunction

   typedef struct packed {
      logic s3;
      logic s2;
      logic s1;
   } stage_valid_t;

endpackage

// File: rtl/approx_mul_cell.sv
// One column cell: exact full adder, or the approximate cell when approx is set.
module approx_mul_cell
   import approx_mul_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic z,
   input  logic approx,
   output logic s,
   output logic c
);

   always_comb begin
      s = x ^ y ^ z;
      c = (x & y) | (x & z) | (y & z);
      if (approx) begin
         s = approx_s(x, y);
         c = approx_c(y, z);
      end
   end

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage elastic approximate multiplier: S1 operands, S2 carry-save vectors, S3 product.
// Optional error statistics are built when APPROX_MUL_ERR_STATS_EN is defined.
module approx_mul_pipe
   import approx_mul_pkg::*;
#(
   parameter int unsigned WA          = 8,
   parameter int unsigned WB          = 8,
   parameter int unsigned APPROX_COLS = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WA-1:0]      in_a,
   input  logic [WB-1:0]      in_b,
   input  logic               exact_mode,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef APPROX_MUL_ERR_STATS_EN
   input  logic               stats_clr,
   output logic [31:0]        err_cnt,
   output logic [WA+WB-1:0]   err_max,
`endif
   output logic [WA+WB-1:0]   out_p
);

   localparam int unsigned W  = calc_w(WA, WB);
   localparam int unsigned AC = (APPROX_COLS > W) ? W : APPROX_COLS;

   stage_valid_t  v_q;
   logic          ld1, ld2, ld3;
   logic [WA-1:0] s1_a;
   logic [WB-1:0] s1_b;
   logic          s1_mode;
   logic [W-1:0]  s2_s, s2_c;
   logic          s2_mode;
   logic [W-1:0]  p_q;
   logic [W-1:0]  red_s, red_c, sum;
   logic [W-1:0]  approx1, approx2;

   // A stage loads when it is empty or its content moves on this cycle.
   assign ld3       = ~v_q.s3 | out_ready;
   assign ld2       = ~v_q.s2 | ld3;
   assign ld1       = ~v_q.s1 | ld2;
   assign in_ready  = ld1;
   assign out_valid = v_q.s3;
   assign out_p     = p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
      end else begin
         if (ld1) v_q.s1 <= in_valid;
         if (ld2) v_q.s2 <= v_q.s1;
         if (ld3) v_q.s3 <= v_q.s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a    <= '0;
         s1_b    <= '0;
         s1_mode <= 1'b0;
         s2_s    <= '0;
         s2_c    <= '0;
         s2_mode <= 1'b0;
         p_q     <= '0;
      end else begin
         if (ld1 && in_valid) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_mode <= exact_mode;
         end
         if (ld2 && v_q.s1) begin
            s2_s    <= red_s;
            s2_c    <= red_c;
            s2_mode <= s1_mode;
         end
         if (ld3 && v_q.s2) p_q <= sum;
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_mask
      if (i < AC) begin : g_apx
         assign approx1[i] = ~s1_mode;
         assign approx2[i] = ~s2_mode;
      end else begin : g_ext
         assign approx1[i] = 1'b0;
         assign approx2[i] = 1'b0;
      end
   end

   // Row-wise carry-save; each row block owns its vectors so the chain has no self-feedback.
   for (genvar j = 0; j < WB; j++) begin : g_row
      logic [W-1:0] row, s_vec, c_vec;
      assign row = (W'(s1_a) << j) & {W{s1_b[j]}};
      if (j == 0) begin : g_init
         assign s_vec = row;
         assign c_vec = '0;
      end else begin : g_csa
         logic [W-1:0] k;
         logic         unused_k;
         for (genvar i = 0; i < W; i++) begin : g_col
            approx_mul_cell u_cell (
               .x     (g_row[j-1].s_vec[i]),
               .y     (g_row[j-1].c_vec[i]),
               .z     (row[i]),
               .approx(approx1[i]),
               .s     (s_vec[i]),
               .c     (k[i])
            );
         end
         assign c_vec    = {k[W-2:0], 1'b0};
         assign unused_k = k[W-1];
      end
   end

   assign red_s = g_row[WB-1].s_vec;
   assign red_c = g_row[WB-1].c_vec;

   for (genvar i = 0; i < W; i++) begin : g_add
      logic cy_in, cy_out;
      if (i == 0) begin : g_lsb
         assign cy_in = 1'b0;
      end else begin : g_chain
         assign cy_in = g_add[i-1].cy_out;
      end
      approx_mul_cell u_cell (
         .x     (s2_s[i]),
         .y     (s2_c[i]),
         .z     (cy_in),
         .approx(approx2[i]),
         .s     (sum[i]),
         .c     (cy_out)
      );
   end

   logic unused_carry;
   assign unused_carry = g_add[W-1].cy_out;

`ifdef APPROX_MUL_ERR_STATS_EN
   logic [WA-1:0] s2_a;
   logic [WB-1:0] s2_b;
   logic [W-1:0]  exact_q, err_diff, err_max_q;
   logic [31:0]   err_cnt_q;
   logic          emit;

   assign emit     = v_q.s3 & out_ready;
   assign err_diff = (p_q > exact_q) ? (p_q - exact_q) : (exact_q - p_q);
   assign err_cnt  = err_cnt_q;
   assign err_max  = err_max_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_a    <= '0;
         s2_b    <= '0;
         exact_q <= '0;
      end else begin
         if (ld2 && v_q.s1) begin
            s2_a <= s1_a;
            s2_b <= s1_b;
         end
         if (ld3 && v_q.s2) exact_q <= W'(s2_a) * W'(s2_b);
      end
   end

   // Clear wins over a same-cycle emit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
         err_max_q <= '0;
      end else if (stats_clr) begin
         err_cnt_q <= '0;
         err_max_q <= '0;
      end else if (emit) begin
         if ((p_q != exact_q) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 32'd1;
         if (err_diff > err_max_q) err_max_q <= err_diff;
      end
   end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe: default 8x8/10-column instance plus an exact 12x12 instance.
// Statistics checks are built when APPROX_MUL_ERR_STATS_EN is defined.
module tb_approx_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready, exact_mode, out_valid, out_ready;
   logic [7:0]  in_a, in_b;
   logic [15:0] out_p;

   logic        x_in_valid, x_in_ready, x_mode, x_out_valid, x_out_ready;
   logic [11:0] x_a, x_b;
   logic [23:0] x_p;

`ifdef APPROX_MUL_ERR_STATS_EN
   logic        stats_clr;
   logic [31:0] err_cnt, x_err_cnt;
   logic [15:0] err_max;
   logic [23:0] x_err_max;
`endif

   int n_vec = 0;
   int n_err = 0;
   int stall_cnt = 0;
   int acc;
   logic [7:0] ops_a [5];
   logic [7:0] ops_b [5];
   longint unsigned exp_q[$];
   longint unsigned xq[$];

   always #5 clk = ~clk;

   approx_mul_pipe #(.WA(8), .WB(8), .APPROX_COLS(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .exact_mode(exact_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef APPROX_MUL_ERR_STATS_EN
      .stats_clr (stats_clr),
      .err_cnt   (err_cnt),
      .err_max   (err_max),
`endif
      .out_p     (out_p)
   );

   approx_mul_pipe #(.WA(12), .WB(12), .APPROX_COLS(0)) dut_x (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (x_in_valid),
      .in_ready  (x_in_ready),
      .in_a      (x_a),
      .in_b      (x_b),
      .exact_mode(x_mode),
      .out_valid (x_out_valid),
      .out_ready (x_out_ready),
`ifdef APPROX_MUL_ERR_STATS_EN
      .stats_clr (stats_clr),
      .err_cnt   (x_err_cnt),
      .err_max   (x_err_max),
`endif
      .out_p     (x_p)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-level model of the cell-array algorithm: carry-save rows, then a ripple add.
   function automatic longint unsigned ref_mul(input longint unsigned a, input longint unsigned b,
                                               input int wa, input int wb, input int ac,
                                               input bit mode);
      int              w = wa + wb;
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned s, c, r, ns, k, p;
      bit              x, y, z, cy, apx;
      s = b[0] ? (a & mask) : 0;
      c = 0;
      for (int j = 1; j < wb; j++) begin
         r  = b[j] ? ((a << j) & mask) : 0;
         ns = 0;
         k  = 0;
         for (int i = 0; i < w; i++) begin
            x   = s[i];
            y   = c[i];
            z   = r[i];
            apx = (i < ac) && !mode;
            ns[i] = apx ? ~(x & y) : (x ^ y ^ z);
            k[i]  = apx ? (~y & z) : ((x & y) | (x & z) | (y & z));
         end
         s = ns;
         c = (k << 1) & mask;
      end
      p  = 0;
      cy = 0;
      for (int i = 0; i < w; i++) begin
         x   = s[i];
         y   = c[i];
         apx = (i < ac) && !mode;
         p[i] = apx ? ~(x & y) : (x ^ y ^ cy);
         cy   = apx ? (~y & cy) : ((x & y) | (x & cy) | (y & cy));
      end
      return p;
   endfunction

   task automatic send_exp(input logic [7:0] a, input logic [7:0] b, input bit m,
                           input longint unsigned e);
      int t = 0;
      in_a       = a;
      in_b       = b;
      exact_mode = m;
      in_valid   = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         stall_cnt++;
         @(negedge clk);
      end
      chk("send_accept", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input bit m);
      send_exp(a, b, m, ref_mul(64'(a), 64'(b), 8, 8, 10, m));
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic stall_step();
      @(negedge clk);
      if (in_ready && acc < 5) begin
         exp_q.push_back(ref_mul(64'(ops_a[acc]), 64'(ops_b[acc]), 8, 8, 10, 1'b0));
         acc++;
      end
      @(posedge clk);
      #1;
      if (acc < 5) begin
         in_a = ops_a[acc];
         in_b = ops_b[acc];
      end else begin
         in_valid = 1'b0;
      end
   endtask

   // Main output monitor: order, content and hold-while-stalled.
   bit              hold = 1'b0;
   logic [15:0]     held_p;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_p), 64'(held_p));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_output: got 0x%0h, expected none at %0t", out_p, $time);
            end else begin
               chk("product", 64'(out_p), exp_q.pop_front());
            end
         end
         hold   = out_valid && !out_ready;
         held_p = out_p;
      end
   end

   // Exact instance: free-running random traffic with random back-pressure.
   initial begin : x_drv
      bit x_acc;
      x_in_valid  = 1'b1;
      x_a         = 12'($urandom);
      x_b         = 12'($urandom);
      x_mode      = 1'b0;
      x_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         x_acc = rst_n && x_in_ready;
         if (x_acc) xq.push_back(64'(x_a) * 64'(x_b));
         @(posedge clk);
         #1;
         if (x_acc) begin
            x_a    = 12'($urandom);
            x_b    = 12'($urandom);
            x_mode = 1'($urandom);
         end
         x_out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n && x_out_valid && x_out_ready) begin
         if (xq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL x_spurious_output: got 0x%0h, expected none at %0t", x_p, $time);
         end else begin
            chk("x_product", 64'(x_p), xq.pop_front());
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, expected completion at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      exact_mode = 1'b0;
      out_ready  = 1'b1;
`ifdef APPROX_MUL_ERR_STATS_EN
      stats_clr  = 1'b0;
`endif
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_p", 64'(out_p), 64'd0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", 64'(in_ready), 64'd1);

      // Zero operands: approximate columns leak ones, exact mode does not.
      send_exp(8'h00, 8'h00, 1'b0, 64'h03FF);
      send_exp(8'h00, 8'h00, 1'b1, 64'h0000);
      in_valid = 1'b0;
      wait_drain();

      send_exp(8'hAB, 8'hCD, 1'b1, 64'h88EF);
      in_valid = 1'b0;
      wait_drain();

      // Latency: out_valid rises on the third edge counting the accepting one.
      send_exp(8'hFF, 8'hFF, 1'b1, 64'hFE01);
      in_valid = 1'b0;
      chk("latency_edge1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("latency_edge2", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("latency_edge3", 64'(out_valid), 64'd1);
      wait_drain();

      stall_cnt = 0;
      for (int n = 0; n < 1000; n++) send(8'($urandom), 8'($urandom), 1'($urandom));
      in_valid = 1'b0;
      wait_drain();
      chk("throughput_stalls", 64'(stall_cnt), 64'd0);

      // Back-pressure: only three fit, then release.
      for (int n = 0; n < 5; n++) begin
         ops_a[n] = 8'($urandom);
         ops_b[n] = 8'($urandom);
      end
      out_ready  = 1'b0;
      acc        = 0;
      exact_mode = 1'b0;
      in_a       = ops_a[0];
      in_b       = ops_b[0];
      in_valid   = 1'b1;
      repeat (10) stall_step();
      chk("stall_accepted", 64'(acc), 64'd3);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      for (int t = 0; t < 20 && acc < 5; t++) stall_step();
      in_valid = 1'b0;
      chk("stall_total", 64'(acc), 64'd5);
      wait_drain();

      // Reset with a full pipe discards everything in flight.
      out_ready = 1'b0;
      repeat (3) send(8'($urandom), 8'($urandom), 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      exp_q.delete();
      xq.delete();
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_out_p", 64'(out_p), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      repeat (8) @(posedge clk);
      #1;
      chk("no_stale_output", 64'(out_valid), 64'd0);

`ifdef APPROX_MUL_ERR_STATS_EN
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      chk("stats_clr_cnt", 64'(err_cnt), 64'd0);
      chk("stats_clr_max", 64'(err_max), 64'd0);
      send_exp(8'h00, 8'h00, 1'b0, 64'h03FF);
      send_exp(8'h00, 8'h00, 1'b0, 64'h03FF);
      in_valid = 1'b0;
      wait_drain();
      chk("stats_err_cnt", 64'(err_cnt), 64'd2);
      chk("stats_err_max", 64'(err_max), 64'd1023);
      chk("x_stats_err_cnt", 64'(x_err_cnt), 64'd0);
      chk("x_stats_err_max", 64'(x_err_max), 64'd0);
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      chk("stats_clr2_cnt", 64'(err_cnt), 64'd0);
      chk("stats_clr2_max", 64'(err_max), 64'd0);
`endif

      repeat (20) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
